pipe_skid_reg: RTL and testbench

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_skid_reg.sv | 76 +++++++
 tb/tb_pipe_skid_reg.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: two-entry skid stage with registered ready; PIPE_SKID_REG_PERF_EN adds bubble/stall counters
module pipe_skid_reg #(
  parameter int DATA_W = 32,
  parameter int PC_W = 32,
  parameter logic [DATA_W-1:0] NOP_VAL = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [PC_W-1:0]   in_pc_i,
  input  logic [DATA_W-1:0] in_inst_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [PC_W-1:0]   out_pc_o,
  output logic [DATA_W-1:0] out_inst_o,
  output logic [1:0]        occ_o
`ifdef PIPE_SKID_REG_PERF_EN
  ,
  output logic [15:0]       bubble_cnt_o,
  output logic [15:0]       stall_cnt_o
`endif
);
  logic main_v, skid_v;
  logic [PC_W-1:0] main_pc, skid_pc;
  logic [DATA_W-1:0] main_inst, skid_inst;
  logic in_fire, out_fire, load_main, load_skid;
  assign in_ready_o = ~skid_v;
  assign out_valid_o = main_v;
  assign out_pc_o = main_v ? main_pc : '0;
  assign out_inst_o = main_v ? main_inst : NOP_VAL;
  assign occ_o = {main_v & skid_v, main_v ^ skid_v};
  always_comb begin
    in_fire = in_valid_i & in_ready_o;
    out_fire = main_v & out_ready_i;
    load_main = out_fire | ~main_v;
    load_skid = in_fire & main_v & ~out_fire;
  end
  // main refills from skid when one is parked, otherwise straight from the input
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_pc <= '0;
      main_inst <= NOP_VAL;
      skid_pc <= '0;
      skid_inst <= NOP_VAL;
    end else if (flush_i) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else begin
      if (load_main) begin
        main_v <= skid_v | in_fire;
        main_pc <= skid_v ? skid_pc : in_pc_i;
        main_inst <= skid_v ? skid_inst : in_inst_i;
      end
      if (load_skid) begin
        skid_pc <= in_pc_i;
        skid_inst <= in_inst_i;
      end
      skid_v <= skid_v ? ~out_fire : load_skid;
    end
  end
`ifdef PIPE_SKID_REG_PERF_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bubble_cnt_o <= '0;
      stall_cnt_o <= '0;
    end else begin
      if (out_ready_i & ~main_v & ~&bubble_cnt_o) bubble_cnt_o <= bubble_cnt_o + 16'd1;
      if (in_valid_i & ~in_ready_o & ~&stall_cnt_o) stall_cnt_o <= stall_cnt_o + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: directed and random scoreboard checks of the skid stage
module tb_pipe_skid_reg;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk_i = 1'b0, rst_i = 1'b1;
  logic in_valid_i = 1'b0, in_ready_o, flush_i = 1'b0;
  logic out_valid_o, out_ready_i = 1'b0;
  logic [31:0] in_pc_i = '0, in_inst_i = '0, out_pc_o, out_inst_o;
  logic [1:0] occ_o;
`ifdef PIPE_SKID_REG_PERF_EN
  logic [15:0] bubble_cnt_o, stall_cnt_o;
`endif
  typedef struct packed {logic [31:0] pc; logic [31:0] inst;} ent_t;
  ent_t q[$];
  int tests = 0, fails = 0, pushed = 0;
  pipe_skid_reg #(.DATA_W(32), .PC_W(32), .NOP_VAL(NOP)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_pc_i(in_pc_i), .in_inst_i(in_inst_i), .flush_i(flush_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_pc_o(out_pc_o),
    .out_inst_o(out_inst_o), .occ_o(occ_o)
`ifdef PIPE_SKID_REG_PERF_EN
    , .bubble_cnt_o(bubble_cnt_o), .stall_cnt_o(stall_cnt_o)
`endif
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_model();
    chk("occ", 64'(occ_o), 64'(q.size()));
    chk("out_valid", 64'(out_valid_o), 64'(q.size() != 0));
    chk("in_ready", 64'(in_ready_o), 64'(q.size() < 2));
    chk("out_pc", 64'(out_pc_o), q.size() != 0 ? 64'(q[0].pc) : 64'd0);
    chk("out_inst", 64'(out_inst_o), q.size() != 0 ? 64'(q[0].inst) : 64'(NOP));
  endtask
  task automatic cycle();
    if (out_valid_o && out_ready_i && q.size() != 0) void'(q.pop_front());
    if (flush_i) q.delete();
    else if (in_valid_i && in_ready_o) begin
      q.push_back({in_pc_i, in_inst_i});
      pushed++;
    end
    @(posedge clk_i);
    #1;
    chk_model();
  endtask
  task automatic push(input logic [31:0] pc, input logic [31:0] inst);
    in_valid_i = 1'b1;
    in_pc_i = pc;
    in_inst_i = inst;
    cycle();
    in_valid_i = 1'b0;
  endtask
  task automatic do_reset();
    rst_i = 1'b1;
    q.delete();
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask
  initial begin
    #1;
    chk("rst_valid", 64'(out_valid_o), 64'd0);
    chk("rst_ready", 64'(in_ready_o), 64'd1);
    chk("rst_occ", 64'(occ_o), 64'd0);
    chk("rst_inst", 64'(out_inst_o), 64'(NOP));
    chk("rst_pc", 64'(out_pc_o), 64'd0);
    do_reset();
    out_ready_i = 1'b1;
    push(32'h100, 32'h8C22_0004);
    chk("lat_valid", 64'(out_valid_o), 64'd1);
    chk("lat_pc", 64'(out_pc_o), 64'h100);
    chk("lat_inst", 64'(out_inst_o), 64'h8C22_0004);
    chk("lat_occ", 64'(occ_o), 64'd1);
    cycle();
    chk("drain_occ", 64'(occ_o), 64'd0);
    out_ready_i = 1'b0;
    push(32'h10, 32'hA);
    push(32'h14, 32'hB);
    chk("skid_occ", 64'(occ_o), 64'd2);
    chk("skid_ready", 64'(in_ready_o), 64'd0);
    chk("skid_pc", 64'(out_pc_o), 64'h10);
    cycle();
    chk("hold_pc", 64'(out_pc_o), 64'h10);
    out_ready_i = 1'b1;
    cycle();
    chk("pop1_pc", 64'(out_pc_o), 64'h14);
    chk("pop1_ready", 64'(in_ready_o), 64'd1);
    cycle();
    chk("pop2_valid", 64'(out_valid_o), 64'd0);
    out_ready_i = 1'b0;
    push(32'h30, 32'h1);
    push(32'h34, 32'h2);
    flush_i = 1'b1;
    push(32'h20, 32'h3);
    flush_i = 1'b0;
    chk("flush_valid", 64'(out_valid_o), 64'd0);
    chk("flush_inst", 64'(out_inst_o), 64'(NOP));
    chk("flush_occ", 64'(occ_o), 64'd0);
    out_ready_i = 1'b1;
    repeat (3) cycle();
    out_ready_i = 1'b0;
    push(32'h40, 32'h4);
    push(32'h44, 32'h5);
    chk("pre_arst_occ", 64'(occ_o), 64'd2);
    #2 rst_i = 1'b1;
    #1;
    chk("arst_valid", 64'(out_valid_o), 64'd0);
    chk("arst_ready", 64'(in_ready_o), 64'd1);
    chk("arst_occ", 64'(occ_o), 64'd0);
    chk("arst_inst", 64'(out_inst_o), 64'(NOP));
    chk("arst_pc", 64'(out_pc_o), 64'd0);
    q.delete();
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    chk_model();
    pushed = 0;
    for (int c = 0; c < 20000 && pushed < 1000; c++) begin
      in_valid_i = 1'($urandom_range(0, 1));
      out_ready_i = 1'($urandom_range(0, 1));
      in_pc_i = 32'(pushed) << 2;
      in_inst_i = $urandom;
      cycle();
    end
    chk("rand_pushed", 64'(pushed), 64'd1000);
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    repeat (3) cycle();
    chk("rand_drained", 64'(q.size()), 64'd0);
`ifdef PIPE_SKID_REG_PERF_EN
    rst_i = 1'b1;
    q.delete();
    out_ready_i = 1'b1;
    #1;
    chk("perf_rst_bub", 64'(bubble_cnt_o), 64'd0);
    chk("perf_rst_stall", 64'(stall_cnt_o), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #1;
    chk("perf_bubble", 64'(bubble_cnt_o), 64'd5);
    out_ready_i = 1'b0;
    push(32'h50, 32'h6);
    push(32'h54, 32'h7);
    in_valid_i = 1'b1;
    repeat (70000) @(posedge clk_i);
    #1;
    chk("perf_stall_sat", 64'(stall_cnt_o), 64'hFFFF);
    in_valid_i = 1'b0;
    flush_i = 1'b1;
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    chk("perf_flush_keep", 64'(stall_cnt_o), 64'hFFFF);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
